// File: rtl/dma_priority_arbiter.sv
// Purpose : 4-channel DMA arbiter; resolves DREQ against mask and priority order, requests the bus, grants one DACK.
// Latency : DREQ -> HRQ 1 cycle; HLDA -> DACK 1 cycle; serviceDone/HLDA drop -> DACK release 1 cycle.
// Backpressure: no grant until HLDA; the grant is held until serviceDone or HLDA drop; no re-arbitration before IDLE.
//
// Ports:
//   CLK, RESET (async, active high)
//   DREQ[3:0], dreqActiveLow          raw channel requests and their polarity
//   dackActiveLow                     DACK active level
//   priorityType                      0 = fixed, 1 = rotating priority
//   controllerDisable                 blocks new arbitration from IDLE
//   maskReg[3:0]                      1 = channel masked
//   HLDA, serviceDone                 CPU hold acknowledge, end-of-service pulse
//   HRQ, DACK[3:0], activeChannel[1:0], grantValid, priorityOrder[7:0], holdTimeout
//
// Optional: define DMA_ARB_HOLD_TIMEOUT_EN to abandon a hold request after
// HOLD_TIMEOUT cycles without HLDA (sets the sticky holdTimeout flag).
module dma_priority_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqActiveLow,
    input  logic              dackActiveLow,
    input  logic              priorityType,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [1:0]        activeChannel,
    output logic              grantValid,
    output logic [7:0]        priorityOrder,
    output logic              holdTimeout
);

    // The priority encoding is 2 bits per channel, so only 4 channels are legal.
    if (NUM_CH != 4 || HOLD_TIMEOUT < 1) begin : g_bad_cfg
        $error("dma_priority_arbiter: NUM_CH must be 4 and HOLD_TIMEOUT >= 1");
    end

    localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_REQ,
        ST_GRANTED,
        ST_RELEASE
    } state_t;

    state_t            state_q;
    logic              hrq_q;
    logic              grant_vld_q;
    logic [1:0]        active_ch_q;
    logic [NUM_CH-1:0] grant_onehot_q;
    logic [7:0]        order_q;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [1:0]        winner;
    logic [7:0]        order_rot_d;

    // Normalise request polarity, then drop masked channels.
    assign req     = (DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskReg;
    assign any_req = |req;

    // Scan from lowest to highest priority slot; the last hit is the winner.
    always_comb begin
        winner = order_q[1:0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[order_q[2*i +: 2]]) begin
                winner = order_q[2*i +: 2];
            end
        end
    end

    // Serviced channel c drops to lowest: slots [7:6]..[1:0] = c, c+3, c+2, c+1 (mod 4).
    always_comb begin
        logic [1:0] c;
        c           = active_ch_q;
        order_rot_d = {c, c + 2'd3, c + 2'd2, c + 2'd1};
    end

`ifdef DMA_ARB_HOLD_TIMEOUT_EN
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    logic [TW-1:0] hold_cnt_q;
    logic          timeout_q;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            hrq_q          <= 1'b0;
            grant_vld_q    <= 1'b0;
            active_ch_q    <= 2'd0;
            grant_onehot_q <= '0;
            order_q        <= FIXED_ORDER;
`ifdef DMA_ARB_HOLD_TIMEOUT_EN
            hold_cnt_q     <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req && !controllerDisable) begin
                        active_ch_q <= winner;
                        hrq_q       <= 1'b1;
                        state_q     <= ST_HOLD_REQ;
`ifdef DMA_ARB_HOLD_TIMEOUT_EN
                        hold_cnt_q  <= '0;
`endif
                    end
                end
                ST_HOLD_REQ: begin
                    if (!any_req) begin
                        hrq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        active_ch_q <= winner;
                        if (HLDA) begin
                            grant_onehot_q <= NUM_CH'(1) << winner;
                            grant_vld_q    <= 1'b1;
                            state_q        <= ST_GRANTED;
                        end
`ifdef DMA_ARB_HOLD_TIMEOUT_EN
                        else if (hold_cnt_q == TW'(HOLD_TIMEOUT - 1)) begin
                            hrq_q     <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                ST_GRANTED: begin
                    // serviceDone wins over a simultaneous HLDA drop.
                    if (serviceDone) begin
                        grant_onehot_q <= '0;
                        grant_vld_q    <= 1'b0;
                        hrq_q          <= 1'b0;
                        state_q        <= ST_RELEASE;
                        if (priorityType) begin
                            order_q <= order_rot_d;
                        end
                    end else if (!HLDA) begin
                        grant_onehot_q <= '0;
                        grant_vld_q    <= 1'b0;
                        hrq_q          <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (!HLDA) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Fixed mode pins the order; this overrides any rotation above.
            if (!priorityType) begin
                order_q <= FIXED_ORDER;
            end
        end
    end

    // The grant itself is registered; polarity is applied from the static
    // command bit so DACK is correct even while RESET is held.
    assign DACK          = grant_onehot_q ^ {NUM_CH{dackActiveLow}};
    assign HRQ           = hrq_q;
    assign grantValid    = grant_vld_q;
    assign activeChannel = active_ch_q;
    assign priorityOrder = order_q;
`ifdef DMA_ARB_HOLD_TIMEOUT_EN
    assign holdTimeout   = timeout_q;
`else
    assign holdTimeout   = 1'b0;
`endif

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel arbiter / bus-request sequencer for the 4-channel DMA controller.
- Resolves DREQ[3:0] against mask and priority mode, raises HRQ, and waits for HLDA.
- Grants exactly one DACK and holds it until timing control reports service complete.
- Maintains the priority order register: fixed or rotating.

Parameters:
- NUM_CH, 4, number of channels; fixed at 4, priority encoding is 2 bits/channel.
- HOLD_TIMEOUT, 16, max cycles waiting for HLDA; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- DREQ  in  4  channel DMA requests; polarity per dreqActiveLow.
- dreqActiveLow  in  1  command reg bit: 1 = DREQ active low.
- dackActiveLow  in  1  command reg bit: 1 = DACK active low.
- priorityType  in  1  command reg bit: 0 = fixed, 1 = rotating.
- controllerDisable  in  1  command reg bit: 1 blocks new arbitration.
- maskReg  in  4  per-channel request mask; 1 = masked.
- HLDA  in  1  hold acknowledge from CPU.
- serviceDone  in  1  one-cycle pulse from timing control: granted channel finished, release bus.
- HRQ  out  1  hold request to CPU.
- DACK  out  4  channel acknowledges; one-hot when active.
- activeChannel  out  2  id of granted or pending channel.
- grantValid  out  1  high while DACK is asserted.
- priorityOrder  out  8  [1:0] highest-priority id … [7:6] lowest.
- holdTimeout  out  1  sticky timeout flag; only with DMA_ARB_HOLD_TIMEOUT_EN, else tied 0.

Behaviour:
- Effective request: req = (DREQ ^ {4{dreqActiveLow}}) & ~maskReg.
- Winner: first channel in priorityOrder, highest to lowest, with req set.
- All outputs are registered. Reset values:
  - HRQ=0, grantValid=0, activeChannel=0, holdTimeout=0, state=IDLE.
  - priorityOrder=8'b11_10_01_00.
  - DACK = 4'b0000 if dackActiveLow=0, else 4'b1111.
- DACK active level follows dackActiveLow every cycle; inactive channels drive the inverse level.
- IDLE:
  - If |req and !controllerDisable at edge n: load activeChannel=winner, HRQ=1 after edge n; go HOLD_REQ.
  - Otherwise remain in IDLE.
- HOLD_REQ:
  - HRQ held at 1.
  - Winner re-evaluated each cycle; activeChannel tracks it.
  - If req==0: HRQ=0 next edge, go IDLE.
  - If HLDA=1 at edge m: latch winner, assert DACK[winner], grantValid=1 after edge m; go GRANTED.
  - Latency DREQ→HRQ = 1 cycle; HLDA→DACK = 1 cycle.
- GRANTED:
  - DACK, activeChannel and HRQ held stable.
  - DREQ, mask and controllerDisable changes are ignored.
  - On serviceDone=1:
    - Deassert DACK, grantValid and HRQ next edge; go RELEASE.
    - If priorityType=1, rotate so serviced channel c becomes lowest: order = {c, c+3, c+2, c+1} mod 4, packed [7:6]..[1:0].
  - If HLDA=0 without serviceDone (CPU abort):
    - Deassert DACK, grantValid and HRQ next edge; go IDLE.
    - No rotation.
  - serviceDone and HLDA fall in the same cycle: treated as serviceDone (rotation applies).
- RELEASE:
  - HRQ=0; go IDLE when HLDA=0.
  - A new request is not arbitrated before IDLE, which guarantees ≥1 HRQ-low cycle between tenures.
- Fixed mode: while priorityType=0, priorityOrder is forced to 8'b11_10_01_00 every cycle. Switching to rotating mode starts from that order.
- Reset mid-operation: all outputs return to reset values asynchronously; any grant in progress is lost.

Optional Feature:
- Macro: DMA_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A counter runs in HOLD_REQ.
  - If HLDA is not seen within HOLD_TIMEOUT cycles: HRQ=0, holdTimeout=1 (sticky until RESET), go IDLE.
  - Re-arbitration is then allowed from the next cycle.
- Undefined:
  - No counter; HOLD_REQ waits for HLDA indefinitely.
  - holdTimeout tied to 0.

Test Plan:
- Fixed priority, DREQ=4'b0110, mask=0, HLDA raised 3 cycles after HRQ -> HRQ=1 one cycle after DREQ; DACK=4'b0010 one cycle after HLDA; activeChannel=1.
- Rotating, channel 2 serviced (serviceDone pulse) -> priorityOrder=8'b10_01_00_11; next DREQ=4'b1111 grants DACK=4'b1000.
- maskReg=4'b0001, DREQ=4'b0001 -> HRQ stays 0 for 10 cycles; DACK=4'b0000.
- dackActiveLow=1, dreqActiveLow=1, DREQ=4'b1011 -> grant channel 2, DACK=4'b1011; idle DACK=4'b1111.
- HLDA dropped mid-GRANTED with priorityType=1 -> DACK inactive and HRQ=0 next cycle; priorityOrder unchanged at 8'b11_10_01_00.
- RESET asserted in GRANTED -> HRQ=0, DACK=4'b0000, priorityOrder=8'b11_10_01_00 immediately. With DMA_ARB_HOLD_TIMEOUT_EN and HLDA held 0 -> HRQ falls after 16 cycles, holdTimeout=1.
